pilha_rpn_param: RTL and testbench
==================================

Name: pilha_rpn_param

Overview:
Clocked RPN calculator stack, the successor to the 2-entry combinational stack model. It holds a real register stack whose width and depth are set by parameters. Push, execute and clear commands are sequenced by a 3-state FSM, which reports underflow and overflow errors and the arithmetic flags. It sits between the keypad/switch front end and the display drivers, and it instantiates the team's ALU slice.

Parameters:
LARGURA, 8, data width of each stack entry and of the ALU.
PROFUNDIDADE, 4, number of stack entries (legal range 2..16).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
entrada  input  LARGURA  operand to push.
operacao  input  3  opcode sampled with entrada_operacao.
entrada_numero  input  1  push request, single-cycle pulse.
entrada_operacao  input  1  execute request, single-cycle pulse.
limpar  input  1  synchronous stack clear.
resultado  output  LARGURA  last ALU result (registered).
display_a  output  LARGURA  top of stack (TOS); 0 if empty.
display_b  output  LARGURA  next-of-stack (NOS); 0 if count<2.
contagem  output  $clog2(PROFUNDIDADE+1)  number of occupied entries.
pilha_vazia  output  1  contagem==0.
pilha_cheia  output  1  contagem==PROFUNDIDADE.
ocupado  output  1  FSM not in OCIOSO.
resultado_valido  output  1  one-cycle pulse when a result is written back.
flag_carry  output  1  carry-out (ADD) or borrow (SUB) of the last op.
flag_zero  output  1  last result == 0.
erro  output  1  sticky error; cleared by limpar or reset.

Behaviour:
- Reset (rst_n=0, async): all stack entries 0, contagem=0, FSM=OCIOSO, every output 0 except pilha_vazia=1. Reset mid-operation aborts the operation with no write-back.
- Opcodes, with A=TOS and B=NOS:
  - 000 ADD: B+A.
  - 001 SUB: B-A.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT: ~A, unary.
  - 110 DUP: pushes A, needs 1 entry and 1 free slot.
  - 111 SWAP: exchanges A and B, no result write; resultado_valido still pulses and resultado=A.
- Arithmetic: modulo 2^LARGURA. Wrap-around is not an error; it is reported only in flag_carry.
- Binary ops pop 2 entries and push 1 (contagem-1). Unary ops replace TOS in place.
- FSM states:
  - OCIOSO: accepts commands.
    - Push, not full: TOS<=entrada and contagem+1, in the same edge. Stays in OCIOSO, no ocupado.
    - Push while full: no change, erro<=1.
    - Valid operation: latches opcode, A and B, then goes to CALCULA.
    - Insufficient operands (binary with contagem<2, unary with contagem<1, DUP when full): no change, erro<=1, stays in OCIOSO.
  - CALCULA: ALU output is registered into resultado, flag_carry and flag_zero; goes to ESCREVE.
  - ESCREVE: stack and contagem are updated; resultado_valido=1 during the following cycle; goes to OCIOSO.
- Latency: command sampled at edge E0 leads to the stack updated at E2, with resultado_valido high between E2 and E3.
- Commands arriving while ocupado=1 are ignored silently (no error).
- entrada_numero and entrada_operacao asserted in the same cycle: neither executes; erro<=1.
- limpar has priority over all commands in OCIOSO: stack cleared, contagem=0, erro=0, flags=0. While ocupado, limpar is held off until OCIOSO; the caller must keep it asserted.
- Stack storage: register array indexed by contagem-1 (TOS). Entries are never shifted; only the pointer moves. Popped entries keep stale data but are never displayed.

Decomposition:
- Shared package pkg_rpn holds:
  - opcode localparams OP_ADD..OP_SWAP;
  - state encoding OCIOSO=2'b00, CALCULA=2'b01, ESCREVE=2'b10;
  - function for required operand count per opcode.
- One sub-module, ula_rpn_param (parameter LARGURA): combinational, inputs A, B and op; outputs Y and carry.

Test Plan:
- Reset, then push 3 and push 4, then ADD → resultado=7, contagem=1, display_a=7, resultado_valido pulses 2 cycles after the op edge, flag_carry=0.
- Push 3, push 4, SUB → display_a=0xFF, flag_carry=1 (borrow). Push 0xFF, push 0x01, ADD → 0x00, flag_zero=1, flag_carry=1.
- Push PROFUNDIDADE values 1..4, then a 5th push of 9 → pilha_cheia=1, erro=1, display_a still 4. DUP → erro stays 1, no change. limpar → contagem=0, erro=0.
- Empty stack: ADD → erro=1, ocupado never rises. Push 5, NOT → display_a=0xFA, contagem=1.
- Push 1, push 2, SWAP → display_a=1, display_b=2. Push during CALCULA is ignored and contagem is unchanged. entrada_numero and entrada_operacao together → erro=1.
- Assert rst_n=0 asynchronously while in CALCULA → outputs clear immediately (no clk edge), FSM=OCIOSO, resultado_valido never pulses. Repeat all tests with LARGURA=16, PROFUNDIDADE=8.

Source files
------------

// File: rtl/pkg_rpn.sv
// ============================================================================
//  pkg_rpn : opcodes, FSM encoding and operand-count helper for the RPN stack
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pkg_rpn;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CALCULA = 2'b01,
        ESCREVE = 2'b10
    } estado_t;

    // Entries that must already be on the stack before the opcode may start
    function automatic logic [1:0] operandos_necessarios(input logic [2:0] op);
        case (op)
            OP_NOT, OP_DUP: operandos_necessarios = 2'd1;
            default:        operandos_necessarios = 2'd2;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ula_rpn_param.sv
// ============================================================================
//  ula_rpn_param : combinational ALU slice, Y = B op A with carry/borrow out
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ula_rpn_param
    import pkg_rpn::*;
#(
    parameter int LARGURA = 8
) (
    input  logic [LARGURA-1:0] a_i,
    input  logic [LARGURA-1:0] b_i,
    input  logic [2:0]         op_i,
    output logic [LARGURA-1:0] y_o,
    output logic               carry_o
);

    logic [LARGURA:0] w_soma;
    logic [LARGURA:0] w_dif;

    // Extra MSB carries the carry-out for ADD and the borrow for SUB
    assign w_soma = {1'b0, b_i} + {1'b0, a_i};
    assign w_dif  = {1'b0, b_i} - {1'b0, a_i};

    always_comb begin
        y_o     = '0;
        carry_o = 1'b0;
        case (op_i)
            OP_ADD:  begin y_o = w_soma[LARGURA-1:0]; carry_o = w_soma[LARGURA]; end
            OP_SUB:  begin y_o = w_dif[LARGURA-1:0];  carry_o = w_dif[LARGURA];  end
            OP_AND:  y_o = b_i & a_i;
            OP_OR:   y_o = b_i | a_i;
            OP_XOR:  y_o = b_i ^ a_i;
            OP_NOT:  y_o = ~a_i;
            default: y_o = a_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pilha_rpn_param.sv
// ============================================================================
//  pilha_rpn_param : clocked RPN register stack with 3-state command FSM
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pilha_rpn_param
    import pkg_rpn::*;
#(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [LARGURA-1:0]                  entrada,
    input  logic [2:0]                          operacao,
    input  logic                                entrada_numero,
    input  logic                                entrada_operacao,
    input  logic                                limpar,
    output logic [LARGURA-1:0]                  resultado,
    output logic [LARGURA-1:0]                  display_a,
    output logic [LARGURA-1:0]                  display_b,
    output logic [$clog2(PROFUNDIDADE+1)-1:0]   contagem,
    output logic                                pilha_vazia,
    output logic                                pilha_cheia,
    output logic                                ocupado,
    output logic                                resultado_valido,
    output logic                                flag_carry,
    output logic                                flag_zero,
    output logic                                erro
);

    localparam int CW = $clog2(PROFUNDIDADE + 1);
    localparam int IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

    estado_t              estado_q, estado_d;
    logic [LARGURA-1:0]   pilha_q [PROFUNDIDADE];
    logic [LARGURA-1:0]   pilha_d [PROFUNDIDADE];
    logic [CW-1:0]        cont_q, cont_d;
    logic [2:0]           op_q, op_d;
    logic [LARGURA-1:0]   a_q, a_d, b_q, b_d;
    logic [LARGURA-1:0]   res_q, res_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 valido_q, valido_d;
    logic                 erro_q, erro_d;

    logic [IW-1:0]        w_idx_tos, w_idx_nos, w_idx_livre;
    logic [LARGURA-1:0]   w_tos, w_nos, w_y;
    logic                 w_carry, w_cheia, w_vazia, w_op_ok;

    // Indices wrap when the stack is short; every use is guarded by contagem
    assign w_idx_tos   = IW'(cont_q - CW'(1));
    assign w_idx_nos   = IW'(cont_q - CW'(2));
    assign w_idx_livre = IW'(cont_q);
    assign w_tos       = pilha_q[w_idx_tos];
    assign w_nos       = pilha_q[w_idx_nos];
    assign w_cheia     = (cont_q == CW'(PROFUNDIDADE));
    assign w_vazia     = (cont_q == '0);
    assign w_op_ok     = (cont_q >= CW'(operandos_necessarios(operacao)))
                         && !((operacao == OP_DUP) && w_cheia);

    ula_rpn_param #(
        .LARGURA (LARGURA)
    ) u_ula (
        .a_i     (a_q),
        .b_i     (b_q),
        .op_i    (op_q),
        .y_o     (w_y),
        .carry_o (w_carry)
    );

    always_comb begin
        estado_d = estado_q;
        pilha_d  = pilha_q;
        cont_d   = cont_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        valido_d = 1'b0;
        erro_d   = erro_q;
        case (estado_q)
            OCIOSO: begin
                if (limpar) begin
                    cont_d  = '0;
                    erro_d  = 1'b0;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                    for (int i = 0; i < PROFUNDIDADE; i++) pilha_d[i] = '0;
                end else if (entrada_numero && entrada_operacao) begin
                    erro_d = 1'b1;
                end else if (entrada_numero) begin
                    if (w_cheia) begin
                        erro_d = 1'b1;
                    end else begin
                        pilha_d[w_idx_livre] = entrada;
                        cont_d               = cont_q + CW'(1);
                    end
                end else if (entrada_operacao) begin
                    if (w_op_ok) begin
                        op_d     = operacao;
                        a_d      = w_tos;
                        b_d      = w_nos;
                        estado_d = CALCULA;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            CALCULA: begin
                res_d    = w_y;
                carry_d  = w_carry;
                zero_d   = (w_y == '0);
                estado_d = ESCREVE;
            end
            ESCREVE: begin
                valido_d = 1'b1;
                estado_d = OCIOSO;
                case (op_q)
                    OP_NOT:  pilha_d[w_idx_tos] = res_q;
                    OP_DUP: begin
                        pilha_d[w_idx_livre] = res_q;
                        cont_d               = cont_q + CW'(1);
                    end
                    OP_SWAP: begin
                        pilha_d[w_idx_tos] = b_q;
                        pilha_d[w_idx_nos] = a_q;
                    end
                    default: begin
                        pilha_d[w_idx_nos] = res_q;
                        cont_d             = cont_q - CW'(1);
                    end
                endcase
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            for (int i = 0; i < PROFUNDIDADE; i++) pilha_q[i] <= '0;
            cont_q   <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pilha_q  <= pilha_d;
            cont_q   <= cont_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
        end
    end

    assign resultado        = res_q;
    assign display_a        = w_vazia ? '0 : w_tos;
    assign display_b        = (cont_q >= CW'(2)) ? w_nos : '0;
    assign contagem         = cont_q;
    assign pilha_vazia      = w_vazia;
    assign pilha_cheia      = w_cheia;
    assign ocupado          = (estado_q != OCIOSO);
    assign resultado_valido = valido_q;
    assign flag_carry       = carry_q;
    assign flag_zero        = zero_q;
    assign erro             = erro_q;

endmodule

`default_nettype wire

// File: tb/tb_pilha_rpn_param.sv
// ============================================================================
//  tb_pilha_rpn_param : directed bench driving an 8x4 and a 16x8 stack in step
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pilha_rpn_param;
    import pkg_rpn::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] entrada;
    logic [2:0]  operacao;
    logic        en_num, en_op, limpar;

    logic [7:0]  res8, da8, db8;
    logic [2:0]  cnt8;
    logic        vz8, ch8, oc8, rv8, cy8, zr8, er8;
    logic [15:0] res16, da16, db16;
    logic [3:0]  cnt16;
    logic        vz16, ch16, oc16, rv16, cy16, zr16, er16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pilha_rpn_param #(.LARGURA(8), .PROFUNDIDADE(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .entrada(entrada[7:0]), .operacao(operacao),
        .entrada_numero(en_num), .entrada_operacao(en_op), .limpar(limpar),
        .resultado(res8), .display_a(da8), .display_b(db8), .contagem(cnt8),
        .pilha_vazia(vz8), .pilha_cheia(ch8), .ocupado(oc8),
        .resultado_valido(rv8), .flag_carry(cy8), .flag_zero(zr8), .erro(er8)
    );

    pilha_rpn_param #(.LARGURA(16), .PROFUNDIDADE(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .entrada(entrada), .operacao(operacao),
        .entrada_numero(en_num), .entrada_operacao(en_op), .limpar(limpar),
        .resultado(res16), .display_a(da16), .display_b(db16), .contagem(cnt16),
        .pilha_vazia(vz16), .pilha_cheia(ch16), .ocupado(oc16),
        .resultado_valido(rv16), .flag_carry(cy16), .flag_zero(zr16), .erro(er16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        entrada = v;
        en_num  = 1'b1;
        @(posedge clk); #1;
        en_num  = 1'b0;
    endtask

    task automatic clear();
        limpar = 1'b1;
        @(posedge clk); #1;
        limpar = 1'b0;
    endtask

    // Issues one opcode and measures edges from the command edge to the pulse
    task automatic do_op(input logic [2:0] o, output int lat8, output int lat16,
                         output logic occ8, output logic occ16);
        operacao = o;
        en_op    = 1'b1;
        @(posedge clk); #1;
        en_op    = 1'b0;
        occ8  = oc8;
        occ16 = oc16;
        lat8  = -1;
        lat16 = -1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (rv8 && lat8 < 0)   lat8  = k;
            if (rv16 && lat16 < 0) lat16 = k;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_flags8"},  {25'd0, vz8, ch8, oc8, rv8, cy8, zr8, er8}, 32'h40);
        check({tag, "_data8"},   {5'd0, res8, da8, db8, cnt8}, 32'h0);
        check({tag, "_flags16"}, {25'd0, vz16, ch16, oc16, rv16, cy16, zr16, er16}, 32'h40);
        check({tag, "_data16"},  {res16, da16 | db16} | {28'd0, cnt16}, 32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   l8, l16;
        logic o8, o16, seen;

        rst_n = 1'b0; entrada = '0; operacao = '0;
        en_num = 1'b0; en_op = 1'b0; limpar = 1'b0;
        #3;
        check_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD 3+4
        push(16'd3); push(16'd4);
        do_op(OP_ADD, l8, l16, o8, o16);
        check("add_res8", res8, 7);
        check("add_res16", res16, 7);
        check("add_cnt8", cnt8, 1);
        check("add_tos8", da8, 7);
        check("add_lat8", l8, 2);
        check("add_lat16", l16, 2);
        check("add_carry8", cy8, 0);

        // SUB 3-4 borrows
        clear(); push(16'd3); push(16'd4);
        do_op(OP_SUB, l8, l16, o8, o16);
        check("sub_tos8", da8, 32'hFF);
        check("sub_tos16", da16, 32'hFFFF);
        check("sub_borrow8", cy8, 1);
        check("sub_borrow16", cy16, 1);

        // all-ones + 1 wraps to zero with carry
        clear(); push(16'hFFFF); push(16'd1);
        do_op(OP_ADD, l8, l16, o8, o16);
        check("wrap_tos8", da8, 0);
        check("wrap_tos16", da16, 0);
        check("wrap_zero8", zr8, 1);
        check("wrap_zero16", zr16, 1);
        check("wrap_carry8", cy8, 1);
        check("wrap_carry16", cy16, 1);
        check("wrap_err8", er8, 0);

        // fill: 8x4 overflows at the 5th push, 16x8 fills exactly
        clear();
        for (int i = 1; i <= 8; i++) push(16'(i));
        check("fill_cnt8", cnt8, 4);
        check("fill_cnt16", cnt16, 8);
        check("fill_full8", ch8, 1);
        check("fill_full16", ch16, 1);
        check("fill_err8", er8, 1);
        check("fill_err16", er16, 0);
        push(16'd9);
        check("ovf_err16", er16, 1);
        check("ovf_tos8", da8, 4);
        check("ovf_tos16", da16, 8);
        check("ovf_cnt16", cnt16, 8);
        do_op(OP_DUP, l8, l16, o8, o16);
        check("dupfull_busy8", o8, 0);
        check("dupfull_busy16", o16, 0);
        check("dupfull_cnt8", cnt8, 4);
        check("dupfull_err8", er8, 1);
        clear();
        check("clr_cnt8", cnt8, 0);
        check("clr_cnt16", cnt16, 0);
        check("clr_err8", er8, 0);
        check("clr_err16", er16, 0);
        check("clr_empty8", vz8, 1);

        // underflow on empty stack
        do_op(OP_ADD, l8, l16, o8, o16);
        check("uf_err8", er8, 1);
        check("uf_err16", er16, 1);
        check("uf_busy8", o8, 0);
        check("uf_busy16", o16, 0);
        check("uf_lat8", l8, -1);

        // NOT 5
        clear(); push(16'd5);
        do_op(OP_NOT, l8, l16, o8, o16);
        check("not_tos8", da8, 32'hFA);
        check("not_tos16", da16, 32'hFFFA);
        check("not_cnt8", cnt8, 1);
        check("not_lat8", l8, 2);

        // SWAP 1,2
        clear(); push(16'd1); push(16'd2);
        do_op(OP_SWAP, l8, l16, o8, o16);
        check("swap_tos8", da8, 1);
        check("swap_nos8", db8, 2);
        check("swap_tos16", da16, 1);
        check("swap_nos16", db16, 2);
        check("swap_res8", res8, 2);
        check("swap_lat8", l8, 2);

        // push during CALCULA is dropped; ADD of 1+2 still lands
        operacao = OP_ADD; en_op = 1'b1;
        @(posedge clk); #1;
        en_op = 1'b0;
        check("busy_calc8", oc8, 1);
        entrada = 16'd7; en_num = 1'b1;
        @(posedge clk); #1;
        en_num = 1'b0;
        @(posedge clk); #1;
        check("busy_cnt8", cnt8, 1);
        check("busy_cnt16", cnt16, 1);
        check("busy_tos8", da8, 3);
        check("busy_err8", er8, 0);

        // simultaneous push and execute
        @(posedge clk); #1;
        en_num = 1'b1; en_op = 1'b1; operacao = OP_DUP;
        @(posedge clk); #1;
        en_num = 1'b0; en_op = 1'b0;
        check("both_err8", er8, 1);
        check("both_err16", er16, 1);
        check("both_cnt8", cnt8, 1);

        // asynchronous reset while in CALCULA
        clear(); push(16'd1); push(16'd2);
        operacao = OP_ADD; en_op = 1'b1;
        @(posedge clk); #1;
        en_op = 1'b0;
        check("arst_busy8", oc8, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy8_after", oc8, 0);
        check("arst_busy16_after", oc16, 0);
        check("arst_cnt8", cnt8, 0);
        check("arst_res8", res8, 0);
        check("arst_cnt16", cnt16, 0);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) rst_n = 1'b1;
            seen = seen | rv8 | rv16;
        end
        check("arst_no_valid", seen, 0);
        check("arst_cnt8_end", cnt8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
